// File: rtl/ap_fifo_chan_buf_if.sv
// rtl/ap_fifo_chan_buf_if.sv - ap_fifo writer/reader handshake bundle for the channel buffer
interface ap_fifo_chan_buf_if #(
    parameter int DATA_WIDTH = 128
) ();
    logic [DATA_WIDTH-1:0] wr_din;
    logic                  wr_write;
    logic                  wr_full;
    logic                  wr_almost_full;
    logic [DATA_WIDTH-1:0] rd_dout;
    logic                  rd_empty_n;
    logic                  rd_read;

    // master: the stream endpoints around the buffer; slave: the buffer itself
    modport master (
        output wr_din, wr_write, rd_read,
        input  wr_full, wr_almost_full, rd_dout, rd_empty_n
    );

    modport slave (
        input  wr_din, wr_write, rd_read,
        output wr_full, wr_almost_full, rd_dout, rd_empty_n
    );
endinterface

// File: rtl/ap_fifo_chan_buf.sv
// rtl/ap_fifo_chan_buf.sv - ap_fifo channel buffer with FWFT reader port and sticky error flags
module ap_fifo_chan_buf #(
    parameter int DATA_WIDTH     = 128,
    parameter int ADDR_WIDTH     = 4,
    parameter int ALMOST_FULL_TH = 12
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    ap_fifo_chan_buf_if.slave   bus,
    input  logic                clr_err,
    output logic [ADDR_WIDTH:0] level,
    output logic                overflow,
    output logic                underflow
);
    localparam int                   DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]  FULL_LEVEL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam int unsigned          AF_TH      = ALMOST_FULL_TH;
    localparam logic [ADDR_WIDTH:0]  AF_LEVEL   = AF_TH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr_nxt;
    logic [ADDR_WIDTH:0]   level_nxt;
    logic                  accept;
    logic                  pop;

    // Both qualifiers use registered flags so nothing depends combinationally on the requests
    assign accept     = bus.wr_write & ~bus.wr_full;
    assign pop        = bus.rd_read & bus.rd_empty_n;
    assign rd_ptr_nxt = rd_ptr + ADDR_WIDTH'(1);

    always_comb begin
        level_nxt = level;
        if (accept && !pop) begin
            level_nxt = level + (ADDR_WIDTH+1)'(1);
        end else if (!accept && pop) begin
            level_nxt = level - (ADDR_WIDTH+1)'(1);
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst && accept) begin
            mem[wr_ptr] <= bus.wr_din;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            level              <= '0;
            bus.wr_full        <= 1'b0;
            bus.wr_almost_full <= 1'b0;
            bus.rd_empty_n     <= 1'b0;
            bus.rd_dout        <= '0;
            overflow           <= 1'b0;
            underflow          <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_nxt;
            end

            level              <= level_nxt;
            bus.wr_full        <= (level_nxt == FULL_LEVEL);
            bus.wr_almost_full <= (level_nxt >= AF_LEVEL);
            bus.rd_empty_n     <= (level_nxt != '0);

            // rd_dout is a head register: refill it from storage, or from wr_din when the
            // incoming word becomes the oldest one; otherwise it keeps its value.
            if (pop) begin
                if (level >= (ADDR_WIDTH+1)'(2)) begin
                    bus.rd_dout <= mem[rd_ptr_nxt];
                end else if (accept) begin
                    bus.rd_dout <= bus.wr_din;
                end
            end else if (level == '0 && accept) begin
                bus.rd_dout <= bus.wr_din;
            end

            overflow  <= (bus.wr_write & bus.wr_full) | (overflow & ~clr_err);
            underflow <= (bus.rd_read & ~bus.rd_empty_n) | (underflow & ~clr_err);
        end
    end
endmodule

// File: tb/tb_ap_fifo_chan_buf.sv
// tb/tb_ap_fifo_chan_buf.sv - scoreboard bench for ap_fifo_chan_buf against a queue model
module tb_ap_fifo_chan_buf;
    localparam int DW    = 128;
    localparam int DEPTH = 16;
    localparam int AF_TH = 12;

    logic          ap_clk = 1'b0;
    logic          ap_rst = 1'b1;
    logic          clr_err = 1'b0;
    logic [4:0]    level;
    logic          overflow;
    logic          underflow;

    ap_fifo_chan_buf_if #(.DATA_WIDTH(DW)) bus ();

    ap_fifo_chan_buf #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (4),
        .ALMOST_FULL_TH(AF_TH)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .bus      (bus.slave),
        .clr_err  (clr_err),
        .level    (level),
        .overflow (overflow),
        .underflow(underflow)
    );

    always #5 ap_clk = ~ap_clk;

    // Reference model: a word queue plus occupancy and the two sticky flags
    logic [DW-1:0] exp_q[$];
    int            mdl_level = 0;
    bit            mdl_ovf   = 1'b0;
    bit            mdl_unf   = 1'b0;
    bit            run       = 1'b0;
    int            n_checks  = 0;
    int            n_pass    = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; called at posedge+1, returns at the next posedge+1
    task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
        int old;
        bit acc;
        bit pp;
        old = mdl_level;
        acc = w && (old < DEPTH);
        pp  = r && (old > 0);
        bus.wr_write = w;
        bus.wr_din   = d;
        bus.rd_read  = r;
        clr_err      = c;
        if (acc) exp_q.push_back(d);
        @(posedge ap_clk);
        #1;
        mdl_level = old + int'(acc) - int'(pp);
        mdl_ovf   = (w && old == DEPTH) || (mdl_ovf && !c);
        mdl_unf   = (r && old == 0) || (mdl_unf && !c);
        bus.wr_write = 1'b0;
        bus.rd_read  = 1'b0;
        clr_err      = 1'b0;
    endtask

    task automatic do_reset();
        ap_rst       = 1'b1;
        bus.wr_write = 1'($urandom);
        bus.rd_read  = 1'($urandom);
        bus.wr_din   = {$urandom, $urandom, $urandom, $urandom};
        clr_err      = 1'($urandom);
        exp_q.delete();
        mdl_level = 0;
        mdl_ovf   = 1'b0;
        mdl_unf   = 1'b0;
        @(posedge ap_clk);
        #1;
        ap_rst       = 1'b0;
        bus.wr_write = 1'b0;
        bus.rd_read  = 1'b0;
        clr_err      = 1'b0;
        check("rst_level", DW'(level), '0);
        check("rst_empty_n", DW'(bus.rd_empty_n), '0);
        check("rst_full", DW'(bus.wr_full), '0);
        check("rst_dout", bus.rd_dout, '0);
        check("rst_flags", DW'({overflow, underflow, bus.wr_almost_full}), '0);
    endtask

    // Monitor: compares registered status against the model and the head word against the queue
    initial begin
        forever begin
            @(negedge ap_clk);
            if (run && !ap_rst) begin
                check("level", DW'(level), DW'(mdl_level));
                check("wr_full", DW'(bus.wr_full), DW'(mdl_level == DEPTH));
                check("wr_almost_full", DW'(bus.wr_almost_full), DW'(mdl_level >= AF_TH));
                check("rd_empty_n", DW'(bus.rd_empty_n), DW'(mdl_level > 0));
                check("overflow", DW'(overflow), DW'(mdl_ovf));
                check("underflow", DW'(underflow), DW'(mdl_unf));
                if (bus.rd_empty_n) begin
                    if (exp_q.size() == 0) begin
                        check("head_present", DW'(1), DW'(0));
                    end else begin
                        check("rd_dout", bus.rd_dout, exp_q[0]);
                    end
                end
                if (bus.rd_read && mdl_level > 0 && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit            w;
        bit            r;
        int            wp;
        int            rp;
        logic [DW-1:0] d;

        bus.wr_write = 1'b0;
        bus.rd_read  = 1'b0;
        bus.wr_din   = '0;
        @(posedge ap_clk);
        #1;
        run = 1'b1;
        do_reset();

        // single word round trip
        step(1'b1, DW'(32'h1), 1'b0, 1'b0);
        check("first_word", bus.rd_dout, DW'(32'h1));
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        // fill to full, then overflow attempt
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(32'h100 + i), 1'b0, 1'b0);
        check("full_level", DW'(level), DW'(16));
        step(1'b1, DW'(32'hDEAD), 1'b0, 1'b0);
        check("ovf_set", DW'(overflow), DW'(1));

        // write+read at full: read wins, write dropped, then drain
        step(1'b1, DW'(32'hBEEF), 1'b1, 1'b0);
        check("full_rw_level", DW'(level), DW'(15));
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);

        // sustained write+read at level 3 across pointer wrap
        for (int i = 0; i < 3; i++) step(1'b1, DW'(32'h200 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, DW'(32'h300 + i), 1'b1, 1'b0);
        check("steady_level", DW'(level), DW'(3));
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

        // underflow: set-dominant over clr_err, then cleared
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        check("unf_set_dominant", DW'(underflow), DW'(1));
        step(1'b0, '0, 1'b0, 1'b1);
        check("unf_cleared", DW'(underflow), DW'(0));

        // reset mid-stream at level 9
        for (int i = 0; i < 9; i++) step(1'b1, DW'(32'h400 + i), 1'b0, 1'b0);
        do_reset();
        step(1'b1, DW'(32'hAB), 1'b0, 1'b0);
        check("post_reset_word", bus.rd_dout, DW'(32'hAB));
        step(1'b0, '0, 1'b1, 1'b0);

        // randomized traffic with changing write/read pressure
        for (int blk = 0; blk < 15; blk++) begin
            wp = $urandom_range(10, 100);
            rp = $urandom_range(10, 100);
            for (int i = 0; i < 200; i++) begin
                w = ($urandom_range(0, 99) < wp);
                r = ($urandom_range(0, 99) < rp);
                d = {$urandom, $urandom, $urandom, $urandom};
                if ($urandom_range(0, 499) == 0) begin
                    do_reset();
                end else begin
                    step(w, d, r, ($urandom_range(0, 31) == 0));
                end
            end
        end
        step(1'b0, '0, 1'b0, 1'b0);

        run = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
